// File: rtl/feeder.sv
// feeder: single-cycle executor for a packed test program with private
// register file and data RAM; Res tracks the last write-back, done on halt.
module feeder #(
    parameter int BUSW = 32,
    parameter int PROGLEN = 5,
    parameter int PLLEN = 69,
    parameter logic [3:0] NOP = 4'd0,
    parameter logic [3:0] LD = 4'd1,
    parameter logic [3:0] STR = 4'd2,
    parameter logic [3:0] BRA = 4'd3,
    parameter logic [3:0] XOR = 4'd4,
    parameter logic [3:0] ADD = 4'd5,
    parameter logic [3:0] ROT = 4'd6,
    parameter logic [3:0] SHF = 4'd7,
    parameter logic [3:0] HLT = 4'd8,
    parameter logic [3:0] CMP = 4'd9
) (
    input  logic                     clk,
    input  logic [PLLEN*PROGLEN-1:0] Program,
    output logic [BUSW-1:0]          Res,
    output logic                     done,
    input  logic                     reset
);
    localparam int PCW = $clog2(PROGLEN + 1);
    localparam logic [BUSW-1:0] W = BUSW'(BUSW);
    localparam logic [BUSW-1:0] P = BUSW'(PROGLEN);
    logic [PCW-1:0] pc = '0;
    logic z = 1'b0;
    logic done_q = 1'b0;
    logic [BUSW-1:0] res_q = '0;
    logic [BUSW-1:0] r [16] = '{default: '0};
    logic [BUSW-1:0] m [16] = '{default: '0};
    int base;
    logic lit, wr_r, wr_m;
    logic [3:0] op;
    logic [BUSW-1:0] src, dst, sv, rd, amt, res, npc;
    assign Res = res_q;
    assign done = done_q;
    // Fields are sliced straight off the bus so the reserved bits never load.
    always_comb begin
        base = int'(pc) * PLLEN;
        lit = Program[base];
        src = BUSW'(Program[base+1 +: BUSW-1]);
        dst = BUSW'(Program[base+BUSW+1 +: BUSW-1]);
        op = Program[base+2*BUSW+1 +: 4];
        sv = lit ? src : r[src[3:0]];
        rd = r[dst[3:0]];
        amt = sv % W;
        res = rd;
        wr_r = 1'b0;
        wr_m = 1'b0;
        case (op)
            LD:  begin res = lit ? src : m[src[3:0]]; wr_r = 1'b1; end
            STR: begin res = sv; wr_m = 1'b1; end
            XOR: begin res = rd ^ sv; wr_r = 1'b1; end
            ADD: begin res = rd + sv; wr_r = 1'b1; end
            ROT: begin res = (rd << amt) | (rd >> (W - amt)); wr_r = 1'b1; end
            SHF: begin res = (sv >= W) ? '0 : rd << sv; wr_r = 1'b1; end
            NOP, CMP, BRA, HLT: ;
            default: ;
        endcase
        npc = (op == BRA && (lit || z)) ? dst : BUSW'(pc) + 1'b1;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= '0;
            z <= 1'b0;
            done_q <= 1'b0;
            res_q <= '0;
            for (int i = 0; i < 16; i++) begin
                r[i] <= '0;
                m[i] <= '0;
            end
        end else if (!done_q) begin
            if (wr_r) r[dst[3:0]] <= res;
            if (wr_m) m[dst[3:0]] <= res;
            if (wr_r || wr_m) res_q <= res;
            if (op == CMP) z <= (rd == sv);
            if (op == HLT) done_q <= 1'b1;
            else begin
                pc <= PCW'(npc);
                // Full-width compare so far branch targets are not aliased by truncation.
                if (npc >= P) done_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_feeder.sv
// tb_feeder: directed programs; expected per-edge Res/done go into a
// scoreboard queue that a monitor drains after every rising edge.
module tb_feeder;
    localparam int W = 32, N = 8, L = 69;
    localparam logic [3:0] NOP = 0, LD = 1, STR = 2, BRA = 3, XOR = 4,
                           ADD = 5, ROT = 6, SHF = 7, HLT = 8, CMP = 9;
    typedef struct packed {
        logic [W-1:0] r;
        logic d;
    } exp_t;
    logic clk = 1'b0, reset = 1'b1, done;
    logic [L*N-1:0] prog = '0;
    logic [W-1:0] res;
    exp_t q[$];
    int tests = 0, fails = 0, edge_n = 0;
    string cur = "init";

    feeder #(.BUSW(W), .PROGLEN(N), .PLLEN(L)) dut (
        .clk(clk), .Program(prog), .Res(res), .done(done), .reset(reset)
    );

    always #5 clk = ~clk;

    function automatic logic [L-1:0] ins(logic [3:0] op, logic [31:0] d, logic [31:0] s, logic lit);
        return {op, 1'b0, d[30:0], 1'b0, s[30:0], lit};
    endfunction

    task automatic put(int i, logic [3:0] op, logic [31:0] d, logic [31:0] s, logic lit);
        prog[i*L +: L] = ins(op, d, s, lit);
    endtask

    task automatic check(string n, logic [W-1:0] ar, logic ad, logic [W-1:0] er, logic ed);
        tests++;
        if (ar !== er || ad !== ed) begin
            fails++;
            $display("FAIL %s: got Res=%h done=%b, expected Res=%h done=%b", n, ar, ad, er, ed);
        end
    endtask

    task automatic ex(logic [W-1:0] r, logic d);
        q.push_back({r, d});
    endtask

    task automatic start(string n);
        cur = n;
        edge_n = 0;
        reset = 1'b1;
        #1;
        check({n, " reset"}, res, done, '0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run(int k);
        repeat (k) @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL %s drain: %0d entries left, expected 0", cur, q.size());
            q.delete();
        end
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            edge_n++;
            check($sformatf("%s edge%0d", cur, edge_n), res, done, e.r, e.d);
        end
    end

    initial begin
        logic [L-1:0] t;
        put(0, STR, 1, 2, 1); put(1, LD, 1, 1, 0); put(2, ADD, 1, 3, 1);
        put(3, STR, 2, 1, 0); put(4, HLT, 0, 0, 0);
        start("basic");
        ex(2, 0); ex(2, 0); ex(5, 0); ex(5, 0); ex(5, 1); ex(5, 1); ex(5, 1);
        run(7);
        check("basic M2", dut.m[2], 1'b0, 5, 1'b0);

        start("midreset");
        ex(2, 0); ex(2, 0);
        run(2);
        start("rerun");
        ex(2, 0); ex(2, 0); ex(5, 0); ex(5, 0); ex(5, 1); ex(5, 1);
        run(6);

        prog = '0;
        put(0, LD, 1, 32'h7FFF_FFFF, 1); put(1, ADD, 1, 1, 0); put(2, ADD, 1, 1, 1);
        put(3, ADD, 1, 1, 1); put(4, HLT, 0, 0, 0);
        start("wrap");
        ex(32'h7FFF_FFFF, 0); ex(32'hFFFF_FFFE, 0); ex(32'hFFFF_FFFF, 0); ex(0, 0); ex(0, 1); ex(0, 1);
        run(6);

        prog = '0;
        put(0, LD, 1, 32'h4000_0000, 1); put(1, ADD, 1, 1, 0); put(2, ADD, 1, 1, 1);
        put(3, ROT, 1, 1, 1); put(4, SHF, 1, 4, 1); put(5, XOR, 1, 32'hF, 1); put(6, HLT, 0, 0, 0);
        start("rotshf");
        ex(32'h4000_0000, 0); ex(32'h8000_0000, 0); ex(32'h8000_0001, 0); ex(3, 0);
        ex(32'h30, 0); ex(32'h3F, 0); ex(32'h3F, 1); ex(32'h3F, 1);
        run(8);

        prog = '0;
        put(0, LD, 1, 0, 1); put(1, ADD, 1, 1, 1); put(2, CMP, 1, 3, 1);
        put(3, BRA, 5, 0, 0); put(4, BRA, 1, 0, 1); put(5, HLT, 0, 0, 0);
        start("loop");
        ex(0, 0); ex(1, 0); ex(1, 0); ex(1, 0); ex(1, 0); ex(2, 0); ex(2, 0);
        ex(2, 0); ex(2, 0); ex(3, 0); ex(3, 0); ex(3, 0); ex(3, 1); ex(3, 1);
        run(14);

        prog = '0;
        start("nops");
        repeat (7) ex(0, 0);
        ex(0, 1); ex(0, 1);
        run(9);

        prog = '0;
        put(0, LD, 1, 5, 1);
        t = ins(ROT, 1, 33, 1);
        t[32] = 1'b1;
        t[64] = 1'b1;
        prog[1*L +: L] = t;
        put(2, 4'd12, 1, 7, 1); put(3, SHF, 1, 32, 1); put(4, BRA, 20, 0, 1);
        start("edge");
        ex(5, 0); ex(32'hA, 0); ex(32'hA, 0); ex(0, 0); ex(0, 1); ex(0, 1);
        run(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
